alu_retire_stage: RTL and testbench
===================================

# alu_retire_stage

Pipeline register stage directly downstream of the ALU in the ARM execute path. It latches the ALU result and NZVC flags with the instruction's condition, opcode, S bit and destination. It evaluates the ARM condition code against the architectural flags and commits the CPSR NZVC update in program order. It presents a register-file write request over a valid/ready handshake. Its `flags[0]` output is the ALU `carry_in` source for ADC/SBC/RSC.

## Interface

Parameters: none; all widths are fixed by the ARM datapath.

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  discard the in-flight instruction and block acceptance this cycle
- `in_valid`  in  1  upstream holds a valid executed instruction
- `in_ready`  out  1  stage accepts this cycle
- `in_cond`  in  4  ARM condition field [31:28]
- `in_opcode`  in  4  ALU opcode, same encoding the ALU decodes
- `in_s`  in  1  S bit
- `in_rd`  in  4  destination register
- `in_res`  in  32  ALU `res`
- `in_nzvc`  in  4  ALU flags, [3]=N [2]=Z [1]=V [0]=C
- `in_shift_c`  in  1  barrel-shifter carry-out
- `out_valid`  out  1  retire slot occupied
- `out_ready`  in  1  register file / PC logic consumes this cycle
- `out_wen`  out  1  write `out_data` to `out_rd`
- `out_rd`  out  4  destination register
- `out_data`  out  32  write data
- `out_pc_write`  out  1  `out_wen` and `out_rd`==15
- `flags`  out  4  architectural NZVC, registered

## Operation

- Accept: `accept` = `in_valid` & `in_ready` & !`flush`.
- `in_ready` = !`reset` & (!`out_valid` | `out_ready`). It is combinational and has no dependence on `in_valid`.
- Condition pass `cp` is evaluated on the current `flags` register:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) 1; 1111 never passes.
- Classes:
  - Logical: 0000, 0001, 1000, 1001, 1100, 1101, 1110, 1111.
  - Arithmetic: 0010–0111, 1010, 1011.
  - Test: 1000–1011. Test ops never write `rd`, and they update flags regardless of `in_s`.
- Flag update when `accept` & `cp` & (`in_s` | test):
  - Arithmetic: `flags` <= `in_nzvc`.
  - Logical: N and Z from `in_nzvc`, C <= `in_shift_c`, V unchanged.
- On accept, the output slot loads:
  - `out_valid`=1
  - `out_wen` = `cp` & !test
  - `out_rd`, `out_data` = `in_rd`, `in_res`
  - `out_pc_write` = `out_wen` & (`in_rd`==15)
- A failed-condition instruction still occupies the slot with `out_wen`=0, so retirement order and count are preserved.
- No accept while `out_valid` & `out_ready`: `out_valid` <= 0 and the other slot fields hold. While `out_valid` & !`out_ready`, all outputs hold stable.
- Flush: `out_valid` <= 0 and `out_wen` <= 0 next edge, with no accept and no flag update. Flush has priority over a simultaneous `in_valid`.
- Reset: `out_valid`=0, `out_wen`=0, `out_rd`=0, `out_data`=0, `out_pc_write`=0, `flags`=4'b0000. `reset` has priority over `flush` and `accept`.

## Timing

- Latency is 1 cycle: an instruction accepted at edge k appears on `out_*` after edge k.
- Throughput is 1 instruction/cycle while `out_ready`=1. Accept and drain in the same cycle is allowed.
- `flags` change on the accept edge. Back-to-back instructions see the predecessor's update with no bubble: instruction k+1 evaluates `cp` on flags updated at edge k.
- Back-pressure: `out_valid`=1 & `out_ready`=0 forces `in_ready`=0, so no flag change occurs until the stalled instruction drains.
- `flags` never changes except on `accept` or `reset`.

## Test plan

- Reset, then ADD (0100), cond 1110, S=1, rd=3, res=0, nzvc=0101, `out_ready`=1 -> next cycle `out_valid`=1, `out_wen`=1, `out_rd`=3, `out_data`=0, `flags`=0101.
- With `flags`=0010, MOV (1101), S=1, res=32'h80000000, nzvc=1000, shift_c=1 -> `flags`=1011 (N=1, Z=0, V kept 1, C=1), `out_data`=32'h80000000.
- With `flags`=0000, cond EQ (0000), ADD rd=5 -> `out_valid`=1, `out_wen`=0, `flags` stays 0000. Follow with cond NE, rd=5 -> `out_wen`=1.
- CMP (1010), S=0, nzvc=0110, rd=7 -> `out_wen`=0, `flags`=0110. Next instruction with cond GT -> fails, because Z=1.
- `out_ready`=0 with slot full, `in_valid`=1, S=1 -> `in_ready`=0, outputs and `flags` hold for 3 cycles. Raise `out_ready` -> old slot drains, new instruction is accepted the same edge and flags update.
- MOV rd=15, res=32'h00000100, AL -> `out_pc_write`=1. Then `flush`=1 with `in_valid`=1 -> next cycle `out_valid`=0 and `flags` unchanged. Then `reset`=1 mid-stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/alu_retire_stage_if.sv
// rtl/alu_retire_stage_if.sv - handshake and bus bundle for the ALU retire stage
interface alu_retire_stage_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond;
  logic [3:0]  in_opcode;
  logic        in_s;
  logic [3:0]  in_rd;
  logic [31:0] in_res;
  logic [3:0]  in_nzvc;
  logic        in_shift_c;
  logic        out_valid;
  logic        out_ready;
  logic        out_wen;
  logic [3:0]  out_rd;
  logic [31:0] out_data;
  logic        out_pc_write;
  logic [3:0]  flags;

  // Environment side: feeds executed instructions, consumes retire slot
  modport master (
    output flush, in_valid, in_cond, in_opcode, in_s, in_rd, in_res, in_nzvc, in_shift_c,
    output out_ready,
    input  in_ready, out_valid, out_wen, out_rd, out_data, out_pc_write, flags
  );

  // Stage side
  modport slave (
    input  flush, in_valid, in_cond, in_opcode, in_s, in_rd, in_res, in_nzvc, in_shift_c,
    input  out_ready,
    output in_ready, out_valid, out_wen, out_rd, out_data, out_pc_write, flags
  );
endinterface

// File: rtl/alu_retire_stage.sv
// rtl/alu_retire_stage.sv - ALU result retire register with ARM condition check and NZVC commit
module alu_retire_stage (
  input  logic               clk,
  input  logic               reset,
  alu_retire_stage_if.slave  bus
);
  logic [3:0]  flags_q;
  logic        out_valid_q;
  logic        out_wen_q;
  logic [3:0]  out_rd_q;
  logic [31:0] out_data_q;
  logic        out_pc_write_q;

  logic cp;
  logic is_test;
  logic is_arith;
  logic accept;
  logic wen_next;
  logic flag_upd;

  logic n_f, z_f, v_f, c_f;
  assign n_f = flags_q[3];
  assign z_f = flags_q[2];
  assign v_f = flags_q[1];
  assign c_f = flags_q[0];

  // Ready depends only on slot occupancy and reset, never on in_valid
  assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // TST/TEQ/CMP/CMN live in 10xx; arithmetic is SUB..RSC plus CMP/CMN
  assign is_test  = (bus.in_opcode[3:2] == 2'b10);
  assign is_arith = (!bus.in_opcode[3] && (bus.in_opcode[2:1] != 2'b00)) ||
                    (bus.in_opcode[3:1] == 3'b101);

  // Condition evaluated against architectural flags, which already reflect the predecessor
  always_comb begin
    cp = 1'b0;
    case (bus.in_cond)
      4'b0000: cp = z_f;
      4'b0001: cp = !z_f;
      4'b0010: cp = c_f;
      4'b0011: cp = !c_f;
      4'b0100: cp = n_f;
      4'b0101: cp = !n_f;
      4'b0110: cp = v_f;
      4'b0111: cp = !v_f;
      4'b1000: cp = c_f && !z_f;
      4'b1001: cp = !c_f || z_f;
      4'b1010: cp = (n_f == v_f);
      4'b1011: cp = (n_f != v_f);
      4'b1100: cp = !z_f && (n_f == v_f);
      4'b1101: cp = z_f || (n_f != v_f);
      4'b1110: cp = 1'b1;
      default: cp = 1'b0;
    endcase
  end

  assign wen_next = cp && !is_test;
  assign flag_upd = accept && cp && (bus.in_s || is_test);

  // Architectural NZVC: logical ops take C from the shifter and keep V
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_upd) begin
      if (is_arith) flags_q <= bus.in_nzvc;
      else          flags_q <= {bus.in_nzvc[3:2], flags_q[1], bus.in_shift_c};
    end
  end

  // Retire slot: failed-condition instructions still occupy it with wen low
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_wen_q      <= 1'b0;
      out_rd_q       <= 4'd0;
      out_data_q     <= 32'd0;
      out_pc_write_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q    <= 1'b0;
      out_wen_q      <= 1'b0;
      out_pc_write_q <= 1'b0;
    end else if (accept) begin
      out_valid_q    <= 1'b1;
      out_wen_q      <= wen_next;
      out_rd_q       <= bus.in_rd;
      out_data_q     <= bus.in_res;
      out_pc_write_q <= wen_next && (bus.in_rd == 4'd15);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_wen      = out_wen_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_pc_write = out_pc_write_q;
  assign bus.flags        = flags_q;
endmodule

// File: tb/tb_alu_retire_stage.sv
// tb/tb_alu_retire_stage.sv - directed self-checking bench for alu_retire_stage
module tb_alu_retire_stage;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_retire_stage_if bus();

  alu_retire_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] cond, input logic [3:0] op,
                       input logic s, input logic [3:0] rd, input logic [31:0] res,
                       input logic [3:0] nzvc, input logic sc);
    bus.in_valid   = v;
    bus.in_cond    = cond;
    bus.in_opcode  = op;
    bus.in_s       = s;
    bus.in_rd      = rd;
    bus.in_res     = res;
    bus.in_nzvc    = nzvc;
    bus.in_shift_c = sc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic v, input logic w, input logic [3:0] rd,
                      input logic [31:0] d, input logic pcw, input logic [3:0] fl);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".out_wen"}, 32'(bus.out_wen), 32'(w));
    check({tag, ".out_rd"}, 32'(bus.out_rd), 32'(rd));
    check({tag, ".out_data"}, bus.out_data, d);
    check({tag, ".out_pc_write"}, 32'(bus.out_pc_write), 32'(pcw));
    check({tag, ".flags"}, 32'(bus.flags), 32'(fl));
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'hE, 4'h4, 1'b0, 4'd0, 32'd0, 4'h0, 1'b0);
    tick();
    tick();
    slot("reset", 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'h0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;

    // ADD AL S=1
    drive(1'b1, 4'hE, 4'h4, 1'b1, 4'd3, 32'd0, 4'b0101, 1'b0);
    #1;
    check("add.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    slot("add", 1'b1, 1'b1, 4'd3, 32'd0, 1'b0, 4'b0101);

    // Set flags 0010, then MOV keeps V and takes shifter C
    drive(1'b1, 4'hE, 4'h4, 1'b1, 4'd1, 32'd1, 4'b0010, 1'b0);
    tick();
    check("setv.flags", 32'(bus.flags), 32'b0010);
    drive(1'b1, 4'hE, 4'hD, 1'b1, 4'd2, 32'h80000000, 4'b1000, 1'b1);
    tick();
    slot("mov", 1'b1, 1'b1, 4'd2, 32'h80000000, 1'b0, 4'b1011);

    // Clear flags, EQ fails (no flag update even with S), NE passes
    drive(1'b1, 4'hE, 4'h4, 1'b1, 4'd1, 32'd2, 4'b0000, 1'b0);
    tick();
    check("clr.flags", 32'(bus.flags), 32'b0000);
    drive(1'b1, 4'h0, 4'h4, 1'b1, 4'd5, 32'h55, 4'b1111, 1'b1);
    tick();
    slot("eq_fail", 1'b1, 1'b0, 4'd5, 32'h55, 1'b0, 4'b0000);
    drive(1'b1, 4'h1, 4'h4, 1'b0, 4'd5, 32'h66, 4'b1111, 1'b0);
    tick();
    slot("ne_pass", 1'b1, 1'b1, 4'd5, 32'h66, 1'b0, 4'b0000);

    // CMP S=0 updates flags, never writes rd; GT then fails, LE passes
    drive(1'b1, 4'hE, 4'hA, 1'b0, 4'd7, 32'h70, 4'b0110, 1'b0);
    tick();
    slot("cmp", 1'b1, 1'b0, 4'd7, 32'h70, 1'b0, 4'b0110);
    drive(1'b1, 4'hC, 4'h4, 1'b0, 4'd2, 32'h71, 4'b0000, 1'b0);
    tick();
    slot("gt_fail", 1'b1, 1'b0, 4'd2, 32'h71, 1'b0, 4'b0110);
    drive(1'b1, 4'hD, 4'h4, 1'b0, 4'd2, 32'h77, 4'b0000, 1'b0);
    tick();
    slot("le_pass", 1'b1, 1'b1, 4'd2, 32'h77, 1'b0, 4'b0110);
    drive(1'b1, 4'hF, 4'h4, 1'b1, 4'd8, 32'h88, 4'b1111, 1'b1);
    tick();
    slot("nv", 1'b1, 1'b0, 4'd8, 32'h88, 1'b0, 4'b0110);

    // Drain with nothing new: valid drops, fields hold
    drive(1'b0, 4'hE, 4'h4, 1'b1, 4'd0, 32'd0, 4'b1111, 1'b1);
    tick();
    slot("drain", 1'b0, 1'b0, 4'd8, 32'h88, 1'b0, 4'b0110);

    // Back-pressure for 3 cycles, then accept-and-drain on the same edge
    drive(1'b1, 4'hE, 4'h4, 1'b0, 4'd9, 32'h99, 4'b0000, 1'b0);
    tick();
    slot("preload", 1'b1, 1'b1, 4'd9, 32'h99, 1'b0, 4'b0110);
    bus.out_ready = 1'b0;
    drive(1'b1, 4'hE, 4'h4, 1'b1, 4'd4, 32'h1234, 4'b1001, 1'b0);
    #1;
    check("stall.in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      slot("stall", 1'b1, 1'b1, 4'd9, 32'h99, 1'b0, 4'b0110);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    slot("release", 1'b1, 1'b1, 4'd4, 32'h1234, 1'b0, 4'b1001);

    // Write to PC, then flush beats a valid input
    drive(1'b1, 4'hE, 4'hD, 1'b0, 4'd15, 32'h100, 4'b0000, 1'b0);
    tick();
    slot("pc", 1'b1, 1'b1, 4'd15, 32'h100, 1'b1, 4'b1001);
    bus.flush = 1'b1;
    drive(1'b1, 4'hE, 4'h4, 1'b1, 4'd3, 32'h33, 4'b0100, 1'b0);
    tick();
    check("flush.out_valid", 32'(bus.out_valid), 32'd0);
    check("flush.out_wen", 32'(bus.out_wen), 32'd0);
    check("flush.flags", 32'(bus.flags), 32'b1001);
    bus.flush = 1'b0;

    // Reset in the middle of a stall clears everything
    drive(1'b1, 4'hE, 4'h4, 1'b0, 4'd6, 32'hABCD, 4'b0000, 1'b0);
    tick();
    slot("preload2", 1'b1, 1'b1, 4'd6, 32'hABCD, 1'b0, 4'b1001);
    bus.out_ready = 1'b0;
    drive(1'b1, 4'hE, 4'h4, 1'b1, 4'd12, 32'hCC, 4'b1111, 1'b0);
    tick();
    slot("stall2", 1'b1, 1'b1, 4'd6, 32'hABCD, 1'b0, 4'b1001);
    reset = 1'b1;
    #1;
    check("rst2.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    slot("rst2", 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'b0000);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
